// File: rtl/uart_tx_frame.sv
// UART transmitter: start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits.
// Define UART_TX_FRAME_PARITY_EN to add the parity_odd port and the parity bit.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 start_sending,
`ifdef UART_TX_FRAME_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 data_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FRAME_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_FINISHED
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          clk_cnt, clk_cnt_n;
  logic [BW-1:0]          bit_idx, bit_idx_n;   // data bit index, reused as stop-bit count
  logic [DATA_BITS-1:0]   data_q, data_n;
`ifdef UART_TX_FRAME_PARITY_EN
  logic                   par_q, par_n;
`endif
  logic                   last_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_q  <= '0;
`ifdef UART_TX_FRAME_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      data_q  <= data_n;
`ifdef UART_TX_FRAME_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign last_clk = (clk_cnt == CLK_LAST);

  // Outputs decode straight from state so an async reset forces the line high at once.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    data_n    = data_q;
`ifdef UART_TX_FRAME_PARITY_EN
    par_n     = par_q;
`endif
    data_out  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE, S_FINISHED: begin
        done = (state == S_FINISHED);
        if (start_sending) begin
          state_n   = S_START;
          data_n    = data_in;
`ifdef UART_TX_FRAME_PARITY_EN
          par_n     = parity_odd;
`endif
          clk_cnt_n = '0;
          bit_idx_n = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        data_out = 1'b0;
        busy     = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        data_out = data_q[bit_idx];
        busy     = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          if (bit_idx == BIT_LAST) begin
            bit_idx_n = '0;
`ifdef UART_TX_FRAME_PARITY_EN
            state_n   = S_PARITY;
`else
            state_n   = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`ifdef UART_TX_FRAME_PARITY_EN
      S_PARITY: begin
        data_out = (^data_q) ^ par_q;
        busy     = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          state_n   = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        busy = 1'b1;
        if (last_clk) begin
          clk_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = S_FINISHED;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;

`ifdef UART_TX_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk, rst_n;
  logic       a_start, a_line, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_start, b_line, b_busy, b_done;
  logic [6:0] b_data;
`ifdef UART_TX_FRAME_PARITY_EN
  logic       a_po, b_po;
`endif
  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .start_sending(a_start),
`ifdef UART_TX_FRAME_PARITY_EN
    .parity_odd(a_po),
`endif
    .data_out(a_line), .busy(a_busy), .done(a_done));

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .start_sending(b_start),
`ifdef UART_TX_FRAME_PARITY_EN
    .parity_odd(b_po),
`endif
    .data_out(b_line), .busy(b_busy), .done(b_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_db(int sel);  return sel == 0 ? 8 : 7; endfunction
  function automatic int p_cpb(int sel); return sel == 0 ? 4 : 2; endfunction
  function automatic int p_sb(int sel);  return sel == 0 ? 1 : 2; endfunction

  // Frame as a list of line levels, one entry per serial bit.
  function automatic bit exp_bit(int sel, logic [8:0] d, bit po, int k);
    bit q[$];
    bit p;
    q.push_back(1'b0);
    p = po;
    for (int i = 0; i < p_db(sel); i++) begin
      q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (PAR == 1) q.push_back(p);
    for (int s = 0; s < p_sb(sel); s++) q.push_back(1'b1);
    return q[k / p_cpb(sel)];
  endfunction

  function automatic int frame_len(int sel);
    return p_cpb(sel) * (1 + p_db(sel) + PAR + p_sb(sel));
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_cyc(string tag, int sel, bit l, bit b, bit d);
    if (sel == 0) chk(tag, {29'd0, a_line, a_busy, a_done}, {29'd0, l, b, d});
    else          chk(tag, {29'd0, b_line, b_busy, b_done}, {29'd0, l, b, d});
  endtask

  task automatic drive(int sel, bit st, logic [8:0] d, bit po);
    if (sel == 0) begin a_start = st; a_data = d[7:0]; end
    else          begin b_start = st; b_data = d[6:0]; end
`ifdef UART_TX_FRAME_PARITY_EN
    if (sel == 0) a_po = po; else b_po = po;
`else
    if (po) begin end
`endif
  endtask

  // Returns at the first cycle after the accepting edge.
  task automatic accept(int sel, logic [8:0] d, bit po);
    @(negedge clk);
    drive(sel, 1'b1, d, po);
    @(negedge clk);
  endtask

  // Checks every cycle of the frame and the done cycle; hold keeps the request up with data nd.
  task automatic check_frame(string tag, int sel, logic [8:0] d, bit po, bit hold, logic [8:0] nd);
    if (hold) drive(sel, 1'b1, nd, po);
    else      drive(sel, 1'b0, 9'($urandom), ~po);
    for (int k = 0; k < frame_len(sel); k++) begin
      chk_cyc(tag, sel, exp_bit(sel, d, po, k), 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_cyc({tag, "_done"}, sel, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic send(string tag, int sel, logic [8:0] d, bit po);
    accept(sel, d, po);
    check_frame(tag, sel, d, po, 1'b0, 9'd0);
    @(negedge clk);
    chk_cyc({tag, "_idle"}, sel, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] rd;
    rst_n = 1'b0;
    drive(0, 1'b0, 9'd0, 1'b0);
    drive(1, 1'b0, 9'd0, 1'b0);

    repeat (3) begin
      @(negedge clk);
      chk_cyc("rst_a", 0, 1'b1, 1'b0, 1'b0);
      chk_cyc("rst_b", 1, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk_cyc("idle_a", 0, 1'b1, 1'b0, 1'b0);
      chk_cyc("idle_b", 1, 1'b1, 1'b0, 1'b0);
    end

    send("basic_a5", 0, 9'h0A5, 1'b0);
`ifdef UART_TX_FRAME_PARITY_EN
    send("par_a5_odd", 0, 9'h0A5, 1'b1);
    send("par_01_even", 0, 9'h001, 1'b0);
`endif
    send("opt_55", 1, 9'h055, 1'b0);

    // Back-to-back: request held, data changes during frame 1.
    accept(0, 9'h03C, 1'b0);
    check_frame("b2b_1", 0, 9'h03C, 1'b0, 1'b1, 9'h0C3);
    @(negedge clk);
    check_frame("b2b_2", 0, 9'h0C3, 1'b0, 1'b0, 9'd0);
    @(negedge clk);
    chk_cyc("b2b_idle", 0, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 3 of configuration A.
    accept(0, 9'h0F0, 1'b0);
    drive(0, 1'b0, 9'h000, 1'b0);
    repeat (16) @(negedge clk);
    chk_cyc("pre_rst_bit3", 0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_cyc("rst_mid_now", 0, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk_cyc("rst_mid_hold", 0, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_cyc("rst_mid_nodone", 0, 1'b1, 1'b0, 1'b0);
    end
    send("post_rst", 0, 9'h05A, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rd = 9'($urandom);
      send("rand", i % 2, rd, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: serialises one word per request with configurable data width, bit period and stop-bit count, plus optional runtime-selectable parity. It sits between a byte/word source (CPU register or FIFO pop side) and the serial pin. It provides the busy/done status the rest of the UART path consumes, now with asynchronous reset and back-to-back frame support.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9
- CLKS_PER_BIT, 2, clock cycles per serial bit (clock freq / baud rate); legal ≥ 2
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  DATA_BITS  word to send; captured on acceptance
- start_sending  input  1  send request; level-sampled, accepted only in IDLE or FINISHED
- parity_odd  input  1  0 = even parity, 1 = odd; captured on acceptance (present only with macro)
- data_out  output  1  serial line, idle high
- busy  output  1  high while a frame is on the line
- done  output  1  one-cycle pulse after the last stop bit

## Operation
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT, FINISHED.
- Reset (rst_n low, asynchronous): state IDLE, data_out=1, busy=0, done=0, counters 0. Reset mid-frame aborts the frame immediately; the line goes high and no done is issued.
- Acceptance: on an edge where state is IDLE or FINISHED and start_sending=1:
  - capture data_in (and parity_odd)
  - state goes to START_BIT, data_out=0, busy=1, bit counter=0, clk counter=0
- start_sending is ignored in all other states. data_in changes after acceptance have no effect.
- Each bit (start, each data bit, parity, each stop bit) drives data_out for exactly CLKS_PER_BIT cycles. The clk counter runs 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 it wraps to 0 and the FSM advances.
- DATA_BITS state: bits are sent LSB first, index 0..DATA_BITS-1, then PARITY_BIT (if compiled in) or STOP_BIT.
- STOP_BIT state: data_out=1 for STOP_BITS×CLKS_PER_BIT cycles, then FINISHED.
- FINISHED lasts one cycle: data_out=1, busy=0, done=1. The next state is IDLE unless a new request is accepted in this cycle.
- IDLE: data_out=1, busy=0, done=0.
- Counter widths: clk counter $clog2(CLKS_PER_BIT) bits, bit index $clog2(DATA_BITS) bits; no overflow for any legal parameter.
- Illegal/unused state encodings return to IDLE with data_out=1.

## Timing
- Request accepted at edge N: data_out=0 and busy=1 from edge N.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS), where P=1 if parity is enabled, else 0.
- Last stop-bit cycle ends at edge N+F. done=1 and busy=0 for the cycle starting at edge N+F.
- Back-to-back: if start_sending is held high, the next start bit begins at edge N+F+1. This gives exactly one clk of idle-high between frames.
- Latency from request to line low: 0 cycles (same edge as acceptance).

## Configuration
- UART_TX_FRAME_PARITY_EN defined:
  - parity_odd port exists
  - PARITY_BIT state is inserted after the data bits
  - parity value = XOR of captured data bits, XOR parity_odd
- Not defined:
  - no parity_odd port and no PARITY_BIT state
  - frame is start + data + stop only

## Test plan
- Reset/idle: rst_n low for 3 cycles, then release with start_sending=0 → data_out=1, busy=0, done=0 held for 20 cycles.
- Basic frame (DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity), data_in=0xA5 → line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); busy high for 40 cycles; done pulses exactly 1 cycle at cycle 41.
- Parity (macro on, same params), 0xA5:
  - parity_odd=0 → parity bit 0, frame 44 cycles
  - parity_odd=1 → parity bit 1
  - data_in=0x01 with parity_odd=0 → parity bit 1
- Options (DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=2), data_in=0x55 → line 0,1,0,1,0,1,0,1,1,1 with 2 cycles per bit; frame 20 cycles.
- Back-to-back: hold start_sending=1 with 0x3C then 0xC3 → second start bit begins 1 cycle after first done pulse; data_in change during frame 1 does not corrupt it.
- Reset mid-frame: assert rst_n during data bit 3 → data_out=1 and busy=0 immediately (before next edge); no done pulse; next request after release produces a clean frame.
